// File: rtl/codec_pkg.sv
// Shared types and constants for the audio codec master.
// FSM state enum, default sample/slot widths, LRCK slot polarity.
package codec_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int   DEF_DATA_BITS = 16;
    localparam int   DEF_SLOT_BITS = 32;
    localparam logic LRCK_LEFT     = 1'b1;

endpackage

// File: rtl/codec_bclk_gen.sv
// Bit-clock divider: AUD_BCLK low then high for BCLK_HALF clks each.
// Ports: clk, rst, run in; bclk out plus one-clk rise/fall strobes.
import codec_pkg::*;

module codec_bclk_gen #(
    parameter int BCLK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    // Strobes mark the clk edge on which bclk toggles.
    assign wrap = run && (div_cnt == DIV_LAST);
    assign rise = wrap && !bclk;
    assign fall = wrap && bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/codec_master.sv
// Master side of the codec serial link: clocks, ADC serializer, DAC deserializer.
// Ports: clk/rst, enable, adc pair + adc_req, dac pair + dac_valid, AUD_* pins.
// Build option: CODEC_LOOPBACK_EN feeds the rx path from AUD_ADCDAT.
import codec_pkg::*;

module codec_master #(
    parameter int BCLK_HALF = 4,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] adc_left,
    input  logic [DATA_BITS-1:0] adc_right,
    output logic                 adc_req,
    output logic [DATA_BITS-1:0] dac_left,
    output logic [DATA_BITS-1:0] dac_right,
    output logic                 dac_valid,
    output logic                 AUD_BCLK,
    output logic                 AUD_ADCLRCK,
    output logic                 AUD_DACLRCK,
    output logic                 AUD_ADCDAT,
    input  logic                 AUD_DACDAT
);

    localparam int CW = $clog2(2 * SLOT_BITS);
    localparam logic [CW-1:0] LAST  = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] SLOT  = CW'(SLOT_BITS);
    localparam logic [CW-1:0] DBITS = CW'(DATA_BITS);

    state_t               state;
    state_t               state_nxt;
    logic                 run;
    logic                 bclk_rise;
    logic                 bclk_fall;
    logic                 start;
    logic                 frame_end;
    logic                 load;
    logic [CW-1:0]        bit_cnt;
    logic [CW-1:0]        nxt_cnt;
    logic [CW-1:0]        cur_k;
    logic                 cur_left;
    logic [DATA_BITS-1:0] tx_l;
    logic [DATA_BITS-1:0] tx_r;
    logic [DATA_BITS-1:0] rx_l;
    logic [DATA_BITS-1:0] rx_r;
    logic                 lrck;
    logic                 adcdat;
    logic                 rx_din;

    // Wire bit for slot position cnt: MSB-first, zero past DATA_BITS.
    function automatic logic tx_bit(
        input logic [CW-1:0]        cnt,
        input logic [DATA_BITS-1:0] l,
        input logic [DATA_BITS-1:0] r
    );
        logic                 left;
        logic [CW-1:0]        k;
        logic [DATA_BITS-1:0] sh;
        left = cnt < SLOT;
        k    = left ? cnt : cnt - SLOT;
        sh   = (left ? l : r) << k;
        return (k < DBITS) ? sh[DATA_BITS-1] : 1'b0;
    endfunction

    assign run      = (state == RUN);
    assign nxt_cnt  = bit_cnt + 1'b1;
    assign cur_left = bit_cnt < SLOT;
    assign cur_k    = cur_left ? bit_cnt : bit_cnt - SLOT;
    assign load     = start || (frame_end && enable);

`ifdef CODEC_LOOPBACK_EN
    assign rx_din = adcdat;
`else
    assign rx_din = AUD_DACDAT;
`endif

    assign AUD_ADCDAT  = adcdat;
    assign AUD_ADCLRCK = lrck;
    assign AUD_DACLRCK = lrck;

    codec_bclk_gen #(
        .BCLK_HALF(BCLK_HALF)
    ) u_bclk (
        .clk (clk),
        .rst (rst),
        .run (run),
        .bclk(AUD_BCLK),
        .rise(bclk_rise),
        .fall(bclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A stop request only takes effect at the frame boundary.
                if (bclk_fall && bit_cnt == LAST) begin
                    frame_end = 1'b1;
                    if (!enable) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            tx_l      <= '0;
            tx_r      <= '0;
            rx_l      <= '0;
            rx_r      <= '0;
            dac_left  <= '0;
            dac_right <= '0;
            dac_valid <= 1'b0;
            adc_req   <= 1'b0;
            lrck      <= 1'b0;
            adcdat    <= 1'b0;
        end else begin
            adc_req   <= 1'b0;
            dac_valid <= 1'b0;
            if (load) begin
                tx_l    <= adc_left;
                tx_r    <= adc_right;
                adc_req <= 1'b1;
            end
            if (start) begin
                bit_cnt <= '0;
                lrck    <= LRCK_LEFT;
                adcdat  <= adc_left[DATA_BITS-1];
            end else if (run) begin
                // MSB arrives first, so a left shift lands it on top.
                if (bclk_rise && cur_k < DBITS) begin
                    if (cur_left) rx_l <= {rx_l[DATA_BITS-2:0], rx_din};
                    else          rx_r <= {rx_r[DATA_BITS-2:0], rx_din};
                end
                if (bclk_fall) begin
                    if (frame_end) begin
                        dac_left  <= rx_l;
                        dac_right <= rx_r;
                        dac_valid <= 1'b1;
                        bit_cnt   <= '0;
                        if (enable) begin
                            lrck   <= LRCK_LEFT;
                            adcdat <= adc_left[DATA_BITS-1];
                        end else begin
                            lrck   <= 1'b0;
                            adcdat <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= nxt_cnt;
                        lrck    <= (nxt_cnt < SLOT) ? LRCK_LEFT : ~LRCK_LEFT;
                        adcdat  <= tx_bit(nxt_cnt, tx_l, tx_r);
                    end
                end
            end
        end
    end

endmodule
